// File: rtl/mem_stage_skid_reg.sv
// EX/MEM pipeline register for LANES-wide bundles: valid/ready handshake, one-entry skid buffer, per-lane kill.
// Optional stall counter on the stall_cycles port, enabled by defining MEM_STALL_CNT_EN.
module mem_stage_skid_reg #(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = 71,
  parameter int CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0]             in_lane_valid,
  input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
  input  logic [LANES-1:0]             kill_mask,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0]             out_lane_valid,
  output logic [LANES*PAYLOAD_W-1:0]   out_payload
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]             stall_cycles
`endif
);

  logic                       main_valid;
  logic [LANES-1:0]           main_lv;
  logic [LANES*PAYLOAD_W-1:0] main_pl;
  logic                       skid_valid;
  logic [LANES-1:0]           skid_lv;
  logic [LANES*PAYLOAD_W-1:0] skid_pl;

  logic                       accept;
  logic [LANES-1:0]           cap_lv;
  logic                       cap_live;
  logic                       main_free;

  // A bundle whose lanes are all killed is accepted but occupies no entry.
  always_comb begin
    accept    = in_valid & ~skid_valid;
    cap_lv    = in_lane_valid & ~kill_mask;
    cap_live  = accept & (|cap_lv);
    main_free = ~main_valid | out_ready;
  end

  assign in_ready       = ~skid_valid;
  assign out_valid      = main_valid;
  assign out_lane_valid = main_lv;
  assign out_payload    = main_pl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_lv    <= '0;
      main_pl    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_lv    <= skid_lv;
        main_pl    <= skid_pl;
      end else begin
        main_valid <= cap_live;
        if (cap_live) begin
          main_lv <= cap_lv;
          main_pl <= in_payload;
        end
      end
    end
  end

  // The skid only fills when main is held; it drains into main as soon as main frees up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_valid <= 1'b0;
      skid_lv    <= '0;
      skid_pl    <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (main_free) begin
      skid_valid <= 1'b0;
    end else if (cap_live) begin
      skid_valid <= 1'b1;
      skid_lv    <= cap_lv;
      skid_pl    <= in_payload;
    end
  end

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (main_valid && !out_ready && !flush && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_skid_reg.sv
// Randomized + directed scoreboard bench for mem_stage_skid_reg; the reference model is a bounded FIFO of bundles.
// Define MEM_STALL_CNT_EN to also exercise the stall counter (CNT_W=4).
module tb_mem_stage_skid_reg;

  localparam int LANES     = 2;
  localparam int PAYLOAD_W = 71;
  localparam int PW        = LANES*PAYLOAD_W;
`ifdef MEM_STALL_CNT_EN
  localparam int CNT_W     = 4;
`else
  localparam int CNT_W     = 32;
`endif

  typedef struct {
    logic [LANES-1:0] lv;
    logic [PW-1:0]    pl;
  } bundle_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LANES-1:0] in_lane_valid = '0;
  logic [PW-1:0]    in_payload = '0;
  logic [LANES-1:0] kill_mask = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [LANES-1:0] out_lane_valid;
  logic [PW-1:0]    out_payload;
`ifdef MEM_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
  int unsigned      model_stall = 0;
`endif

  bundle_t sbq[$];
  int checks = 0;
  int errors = 0;

  mem_stage_skid_reg #(.LANES(LANES), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_payload(in_payload), .kill_mask(kill_mask),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_valid(out_lane_valid), .out_payload(out_payload)
`ifdef MEM_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the register behaves as a FIFO of at most two live bundles.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sbq.delete();
`ifdef MEM_STALL_CNT_EN
      model_stall = 0;
`endif
    end else begin
      automatic bit ready = (sbq.size() < 2);
      automatic bit occupied = (sbq.size() > 0);
      automatic bundle_t b;
`ifdef MEM_STALL_CNT_EN
      if (occupied && !out_ready && !flush && model_stall < (2**CNT_W - 1))
        model_stall = model_stall + 1;
`endif
      if (flush) begin
        sbq.delete();
      end else begin
        if (occupied && out_ready) void'(sbq.pop_front());
        if (in_valid && ready && |(in_lane_valid & ~kill_mask)) begin
          b.lv = in_lane_valid & ~kill_mask;
          b.pl = in_payload;
          sbq.push_back(b);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [PW-1:0] actual, input logic [PW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard head on every falling edge.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("in_ready", PW'(in_ready), PW'(sbq.size() < 2));
      checkOutput("out_valid", PW'(out_valid), PW'(sbq.size() > 0));
      if (sbq.size() > 0) begin
        checkOutput("out_lane_valid", PW'(out_lane_valid), PW'(sbq[0].lv));
        checkOutput("out_payload", out_payload, sbq[0].pl);
      end
`ifdef MEM_STALL_CNT_EN
      checkOutput("stall_cycles", PW'(stall_cycles), PW'(model_stall));
`endif
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a bundle and hold it until the model says the register accepts it.
  task automatic applyStimulus(input logic [LANES-1:0] lv, input logic [LANES-1:0] km, input logic [PW-1:0] pl);
    bit acc;
    in_valid = 1'b1;
    in_lane_valid = lv;
    kill_mask = km;
    in_payload = pl;
    for (int t = 0; t < 100; t++) begin
      acc = (sbq.size() < 2);
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    errors++;
    $display("[TB] FAIL accept_timeout: bundle %h never accepted", pl);
    in_valid = 1'b0;
  endtask

  function automatic logic [PW-1:0] rand_pl();
    return PW'({$urandom, $urandom, $urandom});
  endfunction

  initial begin
    // Reset state checks before the first clock edge.
    #2;
    checkOutput("reset_out_valid", PW'(out_valid), '0);
    checkOutput("reset_out_payload", out_payload, '0);
    checkOutput("reset_in_ready", PW'(in_ready), PW'(1'b1));
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    // Streaming with out_ready high.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) applyStimulus(2'b11, 2'b00, PW'(i));
    idle(3);

    // Back-pressure: A in main, B in skid, C refused until out_ready rises.
    out_ready = 1'b0;
    applyStimulus(2'b11, 2'b00, PW'(32'hA));
    applyStimulus(2'b11, 2'b00, PW'(32'hB));
    in_valid = 1'b1;
    in_payload = PW'(32'hC);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(2'b11, 2'b00, PW'(32'hC));
    idle(3);

    // Kill: partial and total.
    applyStimulus(2'b11, 2'b10, PW'(32'h11));
    applyStimulus(2'b11, 2'b11, PW'(32'h22));
    idle(3);

    // Flush with both entries full and an incoming bundle.
    out_ready = 1'b0;
    applyStimulus(2'b11, 2'b00, PW'(32'h33));
    applyStimulus(2'b01, 2'b00, PW'(32'h44));
    in_valid = 1'b1;
    in_lane_valid = 2'b11;
    in_payload = PW'(32'h55);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);

    // Async reset mid-cycle with both entries full.
    out_ready = 1'b0;
    applyStimulus(2'b11, 2'b00, PW'(32'h66));
    applyStimulus(2'b11, 2'b00, PW'(32'h77));
    idle(2);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_out_valid", PW'(out_valid), '0);
    checkOutput("async_out_payload", out_payload, '0);
    checkOutput("async_in_ready", PW'(in_ready), PW'(1'b1));
`ifdef MEM_STALL_CNT_EN
    checkOutput("async_stall_cycles", PW'(stall_cycles), '0);
`endif
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

`ifdef MEM_STALL_CNT_EN
    // Stall counter saturation.
    out_ready = 1'b0;
    applyStimulus(2'b11, 2'b00, PW'(32'h88));
    idle(20);
    checkOutput("stall_saturate", PW'(stall_cycles), PW'(15));
    out_ready = 1'b1;
    idle(3);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_lane_valid = LANES'($urandom);
      kill_mask = ($urandom_range(0, 3) == 0) ? LANES'($urandom) : '0;
      in_payload = rand_pl();
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 29) == 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
